hazard_forward_unit: RTL and testbench

Parametrised hazard-detection, forwarding and branch-flush controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It keeps its own shadow copy of the destination register and control bits for the EX, MEM and WB slots. From that state it drives the stall, bubble, flush and operand-forwarding selects that the pipeline buffers and ALU input muxes consume. A mode parameter selects full forwarding or stall-only interlocking. A saturating counter records lost cycles.

---
 rtl/hazard_forward_unit_if.sv | 34 +++
 rtl/hazard_forward_unit.sv | 101 ++++++++++
 tb/tb_hazard_forward_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: ID-stage request and pipeline-control bundle for the hazard unit
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_vld;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              br_taken;
  logic              pc_we;
  logic              ifid_we;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              exmem_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              id_byp_rs;
  logic              id_byp_rt;
  logic [CNT_W-1:0]  stall_cnt;
  modport master (
    output id_vld, id_rs, id_rt, id_use_rt, id_rd, id_regwrite, id_memread, br_taken,
    input  pc_we, ifid_we, idex_bubble, ifid_flush, exmem_flush, fwd_a, fwd_b,
           id_byp_rs, id_byp_rt, stall_cnt
  );
  modport slave (
    input  id_vld, id_rs, id_rt, id_use_rt, id_rd, id_regwrite, id_memread, br_taken,
    output pc_we, ifid_we, idex_bubble, ifid_flush, exmem_flush, fwd_a, fwd_b,
           id_byp_rs, id_byp_rt, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: stall, flush and forwarding control for a 5-stage MIPS pipeline
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_forward_unit_if.slave hz
);
  logic              ex_vld_q, ex_rw_q, ex_mr_q, mem_vld_q, mem_rw_q, mem_mr_q, wb_vld_q, wb_rw_q;
  logic              ex_vld_d, ex_rw_d, ex_mr_d, mem_vld_d, mem_rw_d, mem_mr_d, wb_vld_d, wb_rw_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rs_q, ex_rt_q, mem_rd_q, wb_rd_q;
  logic [REG_AW-1:0] ex_rd_d, ex_rs_d, ex_rt_d, mem_rd_d, wb_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ex_rs_hit, ex_rt_hit, any_rs, any_rt, stall;

  function automatic logic wr(input logic v, input logic rw, input logic [REG_AW-1:0] rd,
                              input logic [REG_AW-1:0] r);
    return v & rw & (rd == r) & (r != '0);
  endfunction

  // Hazard detection, operand-forward selects and pipeline-buffer controls
  always_comb begin
    ex_rs_hit      = wr(ex_vld_q, ex_rw_q, ex_rd_q, hz.id_rs);
    ex_rt_hit      = wr(ex_vld_q, ex_rw_q, ex_rd_q, hz.id_rt) & hz.id_use_rt;
    any_rs         = ex_rs_hit | wr(mem_vld_q, mem_rw_q, mem_rd_q, hz.id_rs)
                   | wr(wb_vld_q, wb_rw_q, wb_rd_q, hz.id_rs);
    any_rt         = ex_rt_hit | ((wr(mem_vld_q, mem_rw_q, mem_rd_q, hz.id_rt)
                   | wr(wb_vld_q, wb_rw_q, wb_rd_q, hz.id_rt)) & hz.id_use_rt);
    stall          = hz.id_vld & ~hz.br_taken
                   & (FWD_EN ? ex_mr_q & (ex_rs_hit | ex_rt_hit) : any_rs | any_rt);
    hz.pc_we       = ~stall;
    hz.ifid_we     = ~stall;
    hz.idex_bubble = stall | hz.br_taken;
    hz.ifid_flush  = hz.br_taken;
    hz.exmem_flush = hz.br_taken;
    hz.fwd_a       = !(FWD_EN && ex_vld_q) ? 2'b00
                   : wr(mem_vld_q, mem_rw_q, mem_rd_q, ex_rs_q) & ~mem_mr_q ? 2'b10
                   : wr(wb_vld_q, wb_rw_q, wb_rd_q, ex_rs_q) ? 2'b01 : 2'b00;
    hz.fwd_b       = !(FWD_EN && ex_vld_q) ? 2'b00
                   : wr(mem_vld_q, mem_rw_q, mem_rd_q, ex_rt_q) & ~mem_mr_q ? 2'b10
                   : wr(wb_vld_q, wb_rw_q, wb_rd_q, ex_rt_q) ? 2'b01 : 2'b00;
    hz.id_byp_rs   = FWD_EN & wr(wb_vld_q, wb_rw_q, wb_rd_q, hz.id_rs);
    hz.id_byp_rt   = FWD_EN & wr(wb_vld_q, wb_rw_q, wb_rd_q, hz.id_rt);
    hz.stall_cnt   = cnt_q;
  end

  // Shadow slots advance every cycle; a taken branch kills the ID and EX entries
  always_comb begin
    ex_vld_d  = hz.id_vld & ~stall & ~hz.br_taken;
    ex_rd_d   = hz.id_rd;
    ex_rw_d   = hz.id_regwrite;
    ex_mr_d   = hz.id_memread;
    ex_rs_d   = hz.id_rs;
    ex_rt_d   = hz.id_rt;
    mem_vld_d = ex_vld_q & ~hz.br_taken;
    mem_rd_d  = ex_rd_q;
    mem_rw_d  = ex_rw_q;
    mem_mr_d  = ex_mr_q;
    wb_vld_d  = mem_vld_q;
    wb_rd_d   = mem_rd_q;
    wb_rw_d   = mem_rw_q;
    cnt_d     = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Slot and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_vld_q  <= 1'b0;
      ex_rd_q   <= '0;
      ex_rw_q   <= 1'b0;
      ex_mr_q   <= 1'b0;
      ex_rs_q   <= '0;
      ex_rt_q   <= '0;
      mem_vld_q <= 1'b0;
      mem_rd_q  <= '0;
      mem_rw_q  <= 1'b0;
      mem_mr_q  <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_rd_q   <= '0;
      wb_rw_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ex_vld_q  <= ex_vld_d;
      ex_rd_q   <= ex_rd_d;
      ex_rw_q   <= ex_rw_d;
      ex_mr_q   <= ex_mr_d;
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      mem_vld_q <= mem_vld_d;
      mem_rd_q  <= mem_rd_d;
      mem_rw_q  <= mem_rw_d;
      mem_mr_q  <= mem_mr_d;
      wb_vld_q  <= wb_vld_d;
      wb_rd_q   <= wb_rd_d;
      wb_rw_q   <= wb_rw_d;
      cnt_q     <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding and stall-only hazard units
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(16)) a ();
  hazard_forward_unit_if #(.REG_AW(5), .CNT_W(2))  b ();

  hazard_forward_unit #(.REG_AW(5), .FWD_EN(1'b1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hz(a));
  hazard_forward_unit #(.REG_AW(5), .FWD_EN(1'b0), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .hz(b));

  task automatic set_a(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] rd, input logic rw, input logic mr);
    a.id_vld = v; a.id_rs = rs; a.id_rt = rt; a.id_use_rt = ur;
    a.id_rd = rd; a.id_regwrite = rw; a.id_memread = mr;
  endtask

  task automatic set_b(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] rd, input logic rw, input logic mr);
    b.id_vld = v; b.id_rs = rs; b.id_rt = rt; b.id_use_rt = ur;
    b.id_rd = rd; b.id_regwrite = rw; b.id_memread = mr;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic drain;
    set_a(0, 0, 0, 0, 0, 0, 0);
    a.br_taken = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset;
    step(); set_a(1, 1, 0, 0, 2, 1, 1);
    step(); set_a(1, 2, 2, 1, 5, 1, 0); #1;
    tests++; if (a.pc_we !== 1'b0) begin fails++; $display("FAIL rst_pre_stall pc_we got %0b exp 0", a.pc_we); end
    step(); set_a(1, 1, 0, 0, 7, 1, 1);
    step(); set_a(1, 7, 0, 0, 8, 1, 0); #1;
    tests++; if (a.pc_we !== 1'b0) begin fails++; $display("FAIL rst_pre_stall2 pc_we got %0b exp 0", a.pc_we); end
    tests++; if (a.stall_cnt !== 16'd1) begin fails++; $display("FAIL rst_pre_cnt got %0d exp 1", a.stall_cnt); end
    #1 rst_n = 1'b0; #1;
    tests++; if (a.pc_we !== 1'b1 || a.ifid_we !== 1'b1) begin fails++; $display("FAIL rst_we pc_we=%0b ifid_we=%0b exp 1 1", a.pc_we, a.ifid_we); end
    tests++; if (a.idex_bubble !== 1'b0 || a.ifid_flush !== 1'b0 || a.exmem_flush !== 1'b0) begin fails++; $display("FAIL rst_ctl bubble=%0b iflush=%0b eflush=%0b exp 0 0 0", a.idex_bubble, a.ifid_flush, a.exmem_flush); end
    tests++; if (a.fwd_a !== 2'b00 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL rst_fwd got %b %b exp 00 00", a.fwd_a, a.fwd_b); end
    tests++; if (a.stall_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", a.stall_cnt); end
    tests++; if (b.stall_cnt !== 2'd0 || b.pc_we !== 1'b1) begin fails++; $display("FAIL rst_b cnt=%0d pc_we=%0b exp 0 1", b.stall_cnt, b.pc_we); end
    set_a(0, 0, 0, 0, 0, 0, 0);
    step(); step(); rst_n = 1'b1;
  endtask

  task automatic test_alu_chain;
    step(); set_a(1, 1, 2, 1, 3, 1, 0);
    step(); set_a(1, 3, 1, 1, 4, 1, 0); #1;
    tests++; if (a.pc_we !== 1'b1 || a.idex_bubble !== 1'b0) begin fails++; $display("FAIL alu_nostall pc_we=%0b bubble=%0b exp 1 0", a.pc_we, a.idex_bubble); end
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b10 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL alu_mem_fwd got %b %b exp 10 00", a.fwd_a, a.fwd_b); end
    step(); set_a(1, 1, 2, 1, 8, 1, 0);
    step(); set_a(1, 1, 2, 1, 9, 1, 0);
    step(); set_a(1, 8, 1, 1, 4, 1, 0);
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b01 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL alu_wb_fwd got %b %b exp 01 00", a.fwd_a, a.fwd_b); end
    step(); set_a(1, 1, 2, 1, 10, 1, 0);
    step(); set_a(1, 1, 2, 1, 9, 1, 0);
    step(); set_a(1, 1, 2, 1, 11, 1, 0);
    step(); set_a(1, 10, 10, 1, 4, 1, 0); #1;
    tests++; if (a.id_byp_rs !== 1'b1 || a.id_byp_rt !== 1'b1) begin fails++; $display("FAIL alu_id_byp got %0b %0b exp 1 1", a.id_byp_rs, a.id_byp_rt); end
    tests++; if (a.fwd_a !== 2'b00 || a.pc_we !== 1'b1) begin fails++; $display("FAIL alu_byp_ctx fwd_a=%b pc_we=%0b exp 00 1", a.fwd_a, a.pc_we); end
    step(); set_a(1, 1, 2, 1, 12, 1, 0);
    step(); set_a(1, 1, 2, 1, 12, 1, 0);
    step(); set_a(1, 12, 12, 1, 4, 1, 0);
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b10 || a.fwd_b !== 2'b10) begin fails++; $display("FAIL alu_mem_over_wb got %b %b exp 10 10", a.fwd_a, a.fwd_b); end
    drain();
  endtask

  task automatic test_load_use;
    step(); set_a(1, 1, 0, 0, 2, 1, 1);
    step(); set_a(1, 2, 2, 1, 5, 1, 0); #1;
    tests++; if (a.pc_we !== 1'b0 || a.ifid_we !== 1'b0 || a.idex_bubble !== 1'b1) begin fails++; $display("FAIL lu_stall pc_we=%0b ifid_we=%0b bubble=%0b exp 0 0 1", a.pc_we, a.ifid_we, a.idex_bubble); end
    tests++; if (a.stall_cnt !== 16'd0) begin fails++; $display("FAIL lu_cnt0 got %0d exp 0", a.stall_cnt); end
    step(); #1;
    tests++; if (a.pc_we !== 1'b1 || a.idex_bubble !== 1'b0) begin fails++; $display("FAIL lu_release pc_we=%0b bubble=%0b exp 1 0", a.pc_we, a.idex_bubble); end
    tests++; if (a.stall_cnt !== 16'd1) begin fails++; $display("FAIL lu_cnt1 got %0d exp 1", a.stall_cnt); end
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b01 || a.fwd_b !== 2'b01) begin fails++; $display("FAIL lu_wb_fwd got %b %b exp 01 01", a.fwd_a, a.fwd_b); end
    drain();
  endtask

  task automatic test_reg0;
    step(); set_a(1, 1, 0, 0, 0, 1, 1);
    step(); set_a(1, 0, 0, 1, 0, 0, 0); #1;
    tests++; if (a.pc_we !== 1'b1 || a.idex_bubble !== 1'b0) begin fails++; $display("FAIL r0_nostall pc_we=%0b bubble=%0b exp 1 0", a.pc_we, a.idex_bubble); end
    step(); set_a(1, 0, 0, 1, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b00 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL r0_mem_fwd got %b %b exp 00 00", a.fwd_a, a.fwd_b); end
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b00 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL r0_wb_fwd got %b %b exp 00 00", a.fwd_a, a.fwd_b); end
    tests++; if (a.stall_cnt !== 16'd1) begin fails++; $display("FAIL r0_cnt got %0d exp 1", a.stall_cnt); end
    drain();
  endtask

  task automatic test_branch;
    step(); set_a(1, 1, 0, 0, 2, 1, 1);
    step(); set_a(1, 2, 2, 1, 5, 1, 0); a.br_taken = 1'b1; #1;
    tests++; if (a.pc_we !== 1'b1 || a.ifid_we !== 1'b1) begin fails++; $display("FAIL br_we pc_we=%0b ifid_we=%0b exp 1 1", a.pc_we, a.ifid_we); end
    tests++; if (a.ifid_flush !== 1'b1 || a.exmem_flush !== 1'b1 || a.idex_bubble !== 1'b1) begin fails++; $display("FAIL br_flush iflush=%0b eflush=%0b bubble=%0b exp 1 1 1", a.ifid_flush, a.exmem_flush, a.idex_bubble); end
    step(); a.br_taken = 1'b0; set_a(1, 2, 2, 1, 5, 1, 0); #1;
    tests++; if (a.pc_we !== 1'b1 || a.idex_bubble !== 1'b0) begin fails++; $display("FAIL br_ex_killed pc_we=%0b bubble=%0b exp 1 0", a.pc_we, a.idex_bubble); end
    tests++; if (a.stall_cnt !== 16'd1) begin fails++; $display("FAIL br_cnt got %0d exp 1", a.stall_cnt); end
    step(); set_a(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (a.fwd_a !== 2'b00 || a.fwd_b !== 2'b00) begin fails++; $display("FAIL br_mem_killed fwd got %b %b exp 00 00", a.fwd_a, a.fwd_b); end
    drain();
  endtask

  task automatic test_stall_only;
    step(); set_b(1, 1, 2, 1, 3, 1, 0);
    step(); set_b(1, 3, 1, 1, 4, 1, 0); #1;
    tests++; if (b.pc_we !== 1'b0 || b.fwd_a !== 2'b00 || b.stall_cnt !== 2'd0) begin fails++; $display("FAIL so_c1 pc_we=%0b fwd_a=%b cnt=%0d exp 0 00 0", b.pc_we, b.fwd_a, b.stall_cnt); end
    step(); #1;
    tests++; if (b.pc_we !== 1'b0 || b.idex_bubble !== 1'b1) begin fails++; $display("FAIL so_c2 pc_we=%0b bubble=%0b exp 0 1", b.pc_we, b.idex_bubble); end
    step(); #1;
    tests++; if (b.pc_we !== 1'b0 || b.stall_cnt !== 2'd2 || b.id_byp_rs !== 1'b0) begin fails++; $display("FAIL so_c3 pc_we=%0b cnt=%0d byp=%0b exp 0 2 0", b.pc_we, b.stall_cnt, b.id_byp_rs); end
    step(); #1;
    tests++; if (b.pc_we !== 1'b1 || b.stall_cnt !== 2'd3) begin fails++; $display("FAIL so_release pc_we=%0b cnt=%0d exp 1 3", b.pc_we, b.stall_cnt); end
    step(); set_b(1, 4, 0, 0, 5, 1, 0); #1;
    tests++; if (b.pc_we !== 1'b0 || b.fwd_a !== 2'b00 || b.fwd_b !== 2'b00) begin fails++; $display("FAIL so_4th pc_we=%0b fwd=%b %b exp 0 00 00", b.pc_we, b.fwd_a, b.fwd_b); end
    step(); set_b(0, 0, 0, 0, 0, 0, 0); #1;
    tests++; if (b.stall_cnt !== 2'd3) begin fails++; $display("FAIL so_sat got %0d exp 3", b.stall_cnt); end
  endtask

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
    a.br_taken = 1'b0;
    b.br_taken = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_reg0();
    test_branch();
    test_stall_only();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
